// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU SPI front-end and the blocks it serves.
package mcu_pkg;

   localparam int NUM_TARGETS_DEF = 4;

   // Target ids carried in the first byte of every chip-select frame
   localparam int TGT_SYS = 0;
   localparam int TGT_HID = 1;
   localparam int TGT_OSD = 2;
   localparam int TGT_SDC = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      DATA    = 2'd2,
      DISCARD = 2'd3
   } state_t;

endpackage

// File: rtl/mcu_spi_if.sv
// MCU SPI pins plus the shared byte bus towards the MCU-facing targets.
interface mcu_spi_if
   import mcu_pkg::*;
#(
   parameter int NUM_TARGETS = NUM_TARGETS_DEF
);

   logic                     spi_clk;
   logic                     spi_ss_n;
   logic                     spi_mosi;
   logic                     spi_miso;
   logic [NUM_TARGETS-1:0]   target;
   logic                     data_in_strobe;
   logic                     data_in_start;
   logic [7:0]               data_in;
   logic [8*NUM_TARGETS-1:0] data_out;

   modport slave (
      input  spi_clk, spi_ss_n, spi_mosi, data_out,
      output spi_miso, target, data_in_strobe, data_in_start, data_in
   );

   modport master (
      output spi_clk, spi_ss_n, spi_mosi, data_out,
      input  spi_miso, target, data_in_strobe, data_in_start, data_in
   );

endinterface

// File: rtl/mcu_spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with rise/fall pulses
// derived from the last synchronized sample and the one before it.
// Flops reset to 0 so a chip select already low at reset release produces
// no falling edge.
module mcu_spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   level;

   // synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave front-end: oversamples the MCU bus in the clk domain,
// routes the first byte of a frame to target selection and forwards the
// remaining bytes as strobes, shifting the selected target's reply back.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | chip select high (or not yet seen falling since reset)
// ADDR    | receiving the target id byte
// DATA    | target selected, payload bytes strobed, replies on MISO
// DISCARD | id out of range, bytes counted and dropped, MISO held 0
module mcu_spi
   import mcu_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_TARGETS = NUM_TARGETS_DEF
) (
   input  logic     clk,
   input  logic     reset_n,
   mcu_spi_if.slave bus
);

   state_t                 state_q, state_d;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;
   logic [2:0]             bit_cnt_q;
   logic [6:0]             rx_q;
   logic [7:0]             rx_byte;
   logic [7:0]             tx_q;
   logic                   start_pending_q;
   logic [NUM_TARGETS-1:0] target_q, onehot;
   logic                   strobe_q, start_q, tx_load_q;
   logic [7:0]             data_in_q, reply;
   logic                   id_ok, byte_done, set_target, issue_strobe;

   mcu_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.spi_clk),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   mcu_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.spi_ss_n),
      .rise    (ss_rise),
      .fall    (ss_fall)
   );

   // mosi takes the same depth as sclk so the sampled bit lines up with its edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mosi_q <= '0;
      else          mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
   end

   assign mosi_s  = mosi_q[SYNC_STAGES-1];
   assign rx_byte = {rx_q, mosi_s};
   assign id_ok   = ({24'd0, rx_byte} < 32'(NUM_TARGETS));

   // id decode and reply mux from the currently selected target
   always_comb begin
      onehot = '0;
      reply  = '0;
      for (int k = 0; k < NUM_TARGETS; k++) begin
         onehot[k] = (rx_byte == 8'(k));
         if (target_q[k]) reply = reply | bus.data_out[8*k +: 8];
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // next state and per-cycle control; chip select rising wins over all
   always_comb begin
      state_d      = state_q;
      byte_done    = (state_q != IDLE) && sclk_rise && (bit_cnt_q == 3'd7);
      set_target   = 1'b0;
      issue_strobe = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall) state_d = ADDR;
         end
         ADDR: begin
            if (byte_done) begin
               if (id_ok) begin
                  state_d    = DATA;
                  set_target = !ss_rise;
               end else begin
                  state_d = DISCARD;
               end
            end
         end
         DATA: begin
            // a byte completing together with ss rising is still delivered
            issue_strobe = byte_done;
         end
         DISCARD: begin
            state_d = DISCARD;
         end
         default: state_d = IDLE;
      endcase
      if (ss_rise && (state_q != IDLE)) state_d = IDLE;
   end

   // receive/transmit shifters, target select and byte strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q       <= '0;
         rx_q            <= '0;
         tx_q            <= '0;
         start_pending_q <= 1'b0;
         target_q        <= '0;
         strobe_q        <= 1'b0;
         start_q         <= 1'b0;
         data_in_q       <= '0;
         tx_load_q       <= 1'b0;
      end else begin
         strobe_q  <= issue_strobe;
         start_q   <= issue_strobe && start_pending_q;
         // targets register their reply off the strobe, so load one clk later
         tx_load_q <= strobe_q;
         if (issue_strobe) begin
            data_in_q       <= rx_byte;
            start_pending_q <= 1'b0;
         end
         if (set_target) begin
            target_q        <= onehot;
            start_pending_q <= 1'b1;
         end
         if (state_q == IDLE) begin
            bit_cnt_q       <= '0;
            rx_q            <= '0;
            tx_q            <= '0;
            start_pending_q <= 1'b0;
            target_q        <= '0;
         end else begin
            if (sclk_rise) begin
               rx_q      <= rx_byte[6:0];
               bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (ss_rise) target_q <= '0;
            if (tx_load_q && (state_q == DATA)) begin
               tx_q <= reply;
            end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
               tx_q <= {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   assign bus.spi_miso       = tx_q[7];
   assign bus.target         = target_q;
   assign bus.data_in_strobe = strobe_q;
   assign bus.data_in_start  = start_q;
   assign bus.data_in        = data_in_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: drives SPI frames, models a registered target
// reply, and checks strobes, target select and MISO bytes.
module tb_mcu_spi;
   import mcu_pkg::*;

   localparam int NT = 4;

   logic clk = 1'b0;
   logic reset_n;

   mcu_spi_if #(.NUM_TARGETS(NT)) bus ();

   mcu_spi #(.SYNC_STAGES(2), .NUM_TARGETS(NT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         proto_err = 0;
   logic       strobe_prev = 1'b0;
   logic       miso_stable = 1'b1;
   logic [7:0] reply_q[$];
   logic [7:0] reply_v;
   logic [7:0] cap_data[$];
   logic       cap_start[$];
   logic [7:0] m[5];

   // registered target: on each strobe the selected target presents its next reply
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.data_out <= {NT{8'hE7}};
      end else if (bus.data_in_strobe) begin
         reply_v = (reply_q.size() > 0) ? reply_q.pop_front() : 8'h00;
         for (int k = 0; k < NT; k++)
            if (bus.target[k]) bus.data_out[8*k +: 8] <= reply_v;
      end
   end

   // capture strobes; flag strobes wider than one clk and stray start flags
   always @(negedge clk) begin
      if (bus.data_in_strobe) begin
         cap_data.push_back(bus.data_in);
         cap_start.push_back(bus.data_in_start);
         if (strobe_prev) proto_err++;
      end
      if (bus.data_in_start && !bus.data_in_strobe) proto_err++;
      strobe_prev = bus.data_in_strobe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ss_begin();
      @(negedge clk);
      bus.spi_ss_n = 1'b0;
   endtask

   task automatic ss_end(input int half);
      @(negedge clk);
      bus.spi_clk = 1'b0;
      repeat (half) @(negedge clk);
      bus.spi_ss_n = 1'b1;
   endtask

   // shift nbits of b out MSB first; MISO captured at each rising edge
   task automatic spi_bits(input logic [7:0] b, input int nbits, input int half,
                           output logic [7:0] miso_b);
      logic pre;
      miso_b = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         @(negedge clk);
         bus.spi_clk  = 1'b0;
         bus.spi_mosi = b[i];
         repeat (half) @(negedge clk);
         pre         = bus.spi_miso;
         bus.spi_clk = 1'b1;
         miso_b[i]   = pre;
         @(negedge clk);
         if (bus.spi_miso !== pre) miso_stable = 1'b0;
         repeat (half - 2) @(negedge clk);
      end
   endtask

   task automatic clear_caps();
      cap_data.delete();
      cap_start.delete();
      reply_q.delete();
      miso_stable = 1'b1;
   endtask

   initial begin
      logic [7:0] dummy;
      reset_n      = 1'b0;
      bus.spi_clk  = 1'b0;
      bus.spi_ss_n = 1'b1;
      bus.spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_miso",   bus.spi_miso, 0);
      chk("rst_target", bus.target, 0);
      chk("rst_strobe", bus.data_in_strobe, 0);
      chk("rst_start",  bus.data_in_start, 0);
      chk("rst_data",   bus.data_in, 0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // sys target, four payload bytes, replies appear one byte later
      clear_caps();
      reply_q = '{8'h5C, 8'h42, 8'h01, 8'h00};
      ss_begin();
      for (int i = 0; i < 5; i++) spi_bits(8'h00, 8, 6, m[i]);
      chk("t1_target", bus.target, 1 << TGT_SYS);
      ss_end(6);
      repeat (8) @(negedge clk);
      chk("t1_nstrobe", cap_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_data%0d", i), cap_data[i], 8'h00);
         chk($sformatf("t1_start%0d", i), cap_start[i], (i == 0) ? 1 : 0);
      end
      chk("t1_miso0", m[0], 8'h00);
      chk("t1_miso1", m[1], 8'h00);
      chk("t1_miso2", m[2], 8'h5C);
      chk("t1_miso3", m[3], 8'h42);
      chk("t1_miso4", m[4], 8'h01);
      chk("t1_stable", miso_stable, 1);
      chk("t1_target_end", bus.target, 0);

      // OSD target, two payload bytes
      clear_caps();
      reply_q = '{8'h99, 8'h00};
      ss_begin();
      spi_bits(8'h02, 8, 6, m[0]);
      spi_bits(8'h04, 8, 6, m[1]);
      spi_bits(8'h41, 8, 6, m[2]);
      chk("t2_target", bus.target, 1 << TGT_OSD);
      ss_end(6);
      repeat (8) @(negedge clk);
      chk("t2_nstrobe", cap_data.size(), 2);
      chk("t2_data0", cap_data[0], 8'h04);
      chk("t2_start0", cap_start[0], 1);
      chk("t2_data1", cap_data[1], 8'h41);
      chk("t2_start1", cap_start[1], 0);
      chk("t2_miso2", m[2], 8'h99);

      // out-of-range id is discarded
      clear_caps();
      ss_begin();
      spi_bits(8'h07, 8, 6, m[0]);
      spi_bits(8'hAA, 8, 6, m[1]);
      chk("t3_target", bus.target, 0);
      ss_end(6);
      repeat (8) @(negedge clk);
      chk("t3_nstrobe", cap_data.size(), 0);
      chk("t3_miso0", m[0], 8'h00);
      chk("t3_miso1", m[1], 8'h00);
      chk("t3_stable", miso_stable, 1);

      // partial byte dropped, then a fresh frame to HID
      clear_caps();
      ss_begin();
      spi_bits(8'h01, 8, 6, m[0]);
      spi_bits(8'hC6, 5, 6, m[1]);
      chk("t4_target_mid", bus.target, 1 << TGT_HID);
      ss_end(6);
      repeat (6) @(negedge clk);
      chk("t4_target_clr", bus.target, 0);
      chk("t4_npartial", cap_data.size(), 0);
      ss_begin();
      spi_bits(8'h01, 8, 6, m[0]);
      spi_bits(8'h33, 8, 6, m[1]);
      ss_end(6);
      repeat (8) @(negedge clk);
      chk("t4_nstrobe", cap_data.size(), 1);
      chk("t4_data", cap_data[0], 8'h33);
      chk("t4_start", cap_start[0], 1);

      // reset mid-byte with ss_n held low
      clear_caps();
      ss_begin();
      spi_bits(8'h01, 8, 6, m[0]);
      spi_bits(8'hF0, 3, 6, m[1]);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t5_miso",   bus.spi_miso, 0);
      chk("t5_target", bus.target, 0);
      chk("t5_strobe", bus.data_in_strobe, 0);
      chk("t5_start",  bus.data_in_start, 0);
      chk("t5_data",   bus.data_in, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      spi_bits(8'h0F, 5, 6, dummy);
      spi_bits(8'h02, 8, 6, dummy);
      spi_bits(8'h77, 8, 6, dummy);
      chk("t5_held_target", bus.target, 0);
      chk("t5_held_nstrobe", cap_data.size(), 0);
      ss_end(6);
      repeat (6) @(negedge clk);
      ss_begin();
      spi_bits(8'h01, 8, 6, m[0]);
      spi_bits(8'h55, 8, 6, m[1]);
      ss_end(6);
      repeat (8) @(negedge clk);
      chk("t5_nstrobe", cap_data.size(), 1);
      chk("t5_data_after", cap_data[0], 8'h55);
      chk("t5_start_after", cap_start[0], 1);

      // minimum SCLK timing, back-to-back frames with a 1-clk ss_n gap
      clear_caps();
      reply_q = '{8'hC3, 8'h7E, 8'h3C, 8'h00};
      ss_begin();
      spi_bits(8'h03, 8, 4, m[0]);
      spi_bits(8'h11, 8, 4, m[1]);
      spi_bits(8'h22, 8, 4, m[2]);
      chk("t6_target_a", bus.target, 1 << TGT_SDC);
      chk("t6a_miso0", m[0], 8'h00);
      chk("t6a_miso1", m[1], 8'h00);
      chk("t6a_miso2", m[2], 8'hC3);
      ss_end(4);
      ss_begin();
      spi_bits(8'h00, 8, 4, m[0]);
      spi_bits(8'h5A, 8, 4, m[1]);
      spi_bits(8'hA5, 8, 4, m[2]);
      chk("t6_target_b", bus.target, 1 << TGT_SYS);
      ss_end(4);
      repeat (8) @(negedge clk);
      chk("t6b_miso0", m[0], 8'h00);
      chk("t6b_miso1", m[1], 8'h00);
      chk("t6b_miso2", m[2], 8'h3C);
      chk("t6_nstrobe", cap_data.size(), 4);
      chk("t6_data0", cap_data[0], 8'h11);
      chk("t6_start0", cap_start[0], 1);
      chk("t6_data1", cap_data[1], 8'h22);
      chk("t6_start1", cap_start[1], 0);
      chk("t6_data2", cap_data[2], 8'h5A);
      chk("t6_start2", cap_start[2], 1);
      chk("t6_data3", cap_data[3], 8'hA5);
      chk("t6_start3", cap_start[3], 0);
      chk("t6_stable", miso_stable, 1);

      chk("strobe_protocol", proto_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
